// File: rtl/if_fetch_queue.sv
// if_fetch_queue: decoupled instruction fetch unit.
// Issues requests on an addr_ok/data_ok split-transaction bus with up to
// DEPTH requests outstanding. Returned words are kept in order with their
// PCs and handed to decode over a valid/allow_in handshake. A redirect
// (flush or taken branch) empties the queue, and responses that are still
// in flight for the dropped entries are counted and discarded when they
// return. A misaligned fetch PC produces one ADEF entry and then fetching
// stops until the next flush.
module if_fetch_queue #(
    parameter int          BR_BUS_WD       = 33,
    parameter int          FS_TO_DS_BUS_WD = 65,
    parameter logic [31:0] RESET_PC        = 32'h1c00_0000,
    parameter int          DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic [31:0]                new_pc,
    input  logic [BR_BUS_WD-1:0]       br_bus,
    output logic                       inst_req,
    output logic [31:0]                inst_addr,
    input  logic                       inst_addr_ok,
    input  logic                       inst_data_ok,
    input  logic [31:0]                inst_rdata,
    output logic                       fs_to_ds_valid,
    input  logic                       ds_allow_in,
    output logic [FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus
);

    localparam int          PW      = $clog2(DEPTH);
    localparam int          CW      = PW + 1;
    localparam logic [CW:0] DEPTH_X = (CW + 1)'(DEPTH);

    // Queue entries. Allocation itself is implied by the pointers and
    // r_occ, so only the filled flag is kept per entry.
    logic [DEPTH-1:0] r_filled;
    logic [DEPTH-1:0] r_adef;
    logic [31:0]      r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];

    logic [31:0]      r_fetch_pc;
    logic [PW-1:0]    r_alloc_ptr;
    logic [PW-1:0]    r_fill_ptr;
    logic [PW-1:0]    r_head_ptr;
    logic [CW-1:0]    r_occ;
    logic [CW-1:0]    r_unfilled;
    logic [CW-1:0]    r_discard;
    logic             r_adef_stop;

    logic             w_br_taken;
    logic [31:0]      w_br_target;
    logic             w_redirect;
    logic [31:0]      w_redirect_pc;
    logic             w_pc_aligned;
    logic [CW:0]      w_inflight;
    logic             w_has_room;
    logic             w_accept;
    logic             w_adef_alloc;
    logic             w_alloc;
    logic             w_fill;
    logic             w_drop;
    logic             w_pop;

    assign w_br_taken    = br_bus[32];
    assign w_br_target   = br_bus[31:0];
    assign w_redirect    = flush | w_br_taken;
    assign w_redirect_pc = flush ? new_pc : w_br_target;
    assign w_pc_aligned  = (r_fetch_pc[1:0] == 2'b00);

    // Stale responses still on the bus occupy a slot until they return, so
    // they are counted against the in-flight limit together with the queue.
    assign w_inflight = {1'b0, r_occ} + {1'b0, r_discard};
    assign w_has_room = (w_inflight < DEPTH_X);

    assign inst_req  = ~reset & ~w_redirect & ~r_adef_stop & w_pc_aligned & w_has_room;
    assign inst_addr = r_fetch_pc;
    assign w_accept  = inst_req & inst_addr_ok;

    // The ADEF entry waits for every older request to be filled, which keeps
    // fill_ptr equal to alloc_ptr when it is inserted already filled.
    assign w_adef_alloc = ~w_redirect & ~r_adef_stop & ~w_pc_aligned
                        & (r_unfilled == '0) & ({1'b0, r_occ} < DEPTH_X);
    assign w_alloc      = w_accept | w_adef_alloc;

    assign w_drop = inst_data_ok & (r_discard != '0);
    assign w_fill = inst_data_ok & (r_discard == '0);

    assign fs_to_ds_valid = r_filled[r_head_ptr];
    assign fs_to_ds_bus   = {r_inst[r_head_ptr], r_adef[r_head_ptr], r_pc[r_head_ptr]};
    assign w_pop          = fs_to_ds_valid & ds_allow_in & ~w_redirect;

    // Fetch PC, queue pointers, occupancy and stale-response bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc  <= RESET_PC;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_occ       <= '0;
            r_unfilled  <= '0;
            r_discard   <= '0;
            r_adef_stop <= 1'b0;
        end else if (w_redirect) begin
            r_fetch_pc  <= w_redirect_pc;
            r_alloc_ptr <= '0;
            r_fill_ptr  <= '0;
            r_head_ptr  <= '0;
            r_occ       <= '0;
            r_unfilled  <= '0;
            r_adef_stop <= 1'b0;
            // Every unfilled entry still has a response coming; one of them
            // (or one already-stale response) may be consumed this cycle.
            r_discard   <= r_discard + r_unfilled - CW'(inst_data_ok);
        end else begin
            if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_alloc) begin
                r_alloc_ptr <= r_alloc_ptr + PW'(1);
            end
            if (w_fill | w_adef_alloc) begin
                r_fill_ptr <= r_fill_ptr + PW'(1);
            end
            if (w_pop) begin
                r_head_ptr <= r_head_ptr + PW'(1);
            end
            if (w_drop) begin
                r_discard <= r_discard - CW'(1);
            end
            if (w_adef_alloc) begin
                r_adef_stop <= 1'b1;
            end
            r_occ      <= r_occ + CW'(w_alloc) - CW'(w_pop);
            r_unfilled <= r_unfilled + CW'(w_accept) - CW'(w_fill);
        end
    end

    // Entry storage: free on pop, allocate at alloc_ptr, fill at fill_ptr.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_filled <= '0;
            r_adef   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]   <= '0;
                r_inst[i] <= '0;
            end
        end else if (w_redirect) begin
            r_filled <= '0;
        end else begin
            if (w_pop) begin
                r_filled[r_head_ptr] <= 1'b0;
            end
            if (w_alloc) begin
                r_filled[r_alloc_ptr] <= w_adef_alloc;
                r_adef[r_alloc_ptr]   <= w_adef_alloc;
                r_pc[r_alloc_ptr]     <= r_fetch_pc;
                r_inst[r_alloc_ptr]   <= '0;
            end
            if (w_fill) begin
                r_filled[r_fill_ptr] <= 1'b1;
                r_inst[r_fill_ptr]   <= inst_rdata;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed bench for if_fetch_queue with a small bus
// responder and an in-order scoreboard checked by an independent monitor.
module tb_if_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic [31:0] new_pc;
    logic [32:0] br_bus;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        fs_to_ds_valid;
    logic        ds_allow_in;
    logic [64:0] fs_to_ds_bus;

    if_fetch_queue #(
        .BR_BUS_WD       (33),
        .FS_TO_DS_BUS_WD (65),
        .RESET_PC        (RESET_PC),
        .DEPTH           (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .new_pc         (new_pc),
        .br_bus         (br_bus),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .fs_to_ds_valid (fs_to_ds_valid),
        .ds_allow_in    (ds_allow_in),
        .fs_to_ds_bus   (fs_to_ds_bus)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_acc = 0;
    logic [31:0] last_acc = '0;
    logic [31:0] pend  [$];
    logic [64:0] exp_q [$];

    // Values applied at the next falling edge.
    logic        nx_reset, nx_flush, nx_br, nx_ok, nx_resp, nx_allow;
    logic [31:0] nx_new_pc, nx_target;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5a5a_0f0f;
    endfunction

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, then record what
    // the bus accepts this cycle.
    task automatic step();
        @(negedge clk);
        reset       = nx_reset;
        flush       = nx_flush;
        new_pc      = nx_new_pc;
        br_bus      = {nx_br, nx_target};
        nx_flush    = 1'b0;
        nx_br       = 1'b0;
        inst_addr_ok = nx_ok;
        ds_allow_in  = nx_allow;
        if (nx_resp && pend.size() > 0) begin
            inst_data_ok = 1'b1;
            inst_rdata   = mem(pend.pop_front());
        end else begin
            inst_data_ok = 1'b0;
            inst_rdata   = '0;
        end
        #1;
        if (inst_req && inst_addr_ok) begin
            pend.push_back(inst_addr);
            exp_q.push_back({mem(inst_addr), 1'b0, inst_addr});
            last_acc = inst_addr;
            n_acc++;
        end
        if (reset) begin
            pend.delete();
            exp_q.delete();
        end else if (flush || br_bus[32]) begin
            exp_q.delete();
        end
    endtask

    task automatic drain();
        int k;
        nx_ok    = 1'b0;
        nx_resp  = 1'b1;
        nx_allow = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while ((exp_q.size() != 0 || pend.size() != 0) && k < 40);
        step();
        check("drain_done", 65'(exp_q.size() == 0 && pend.size() == 0), 65'd1);
    endtask

    // Monitor: every completed handshake must match the oldest expectation.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b0 && fs_to_ds_valid === 1'b1 && ds_allow_in === 1'b1
                && flush === 1'b0 && br_bus[32] === 1'b0) begin
                if (exp_q.size() == 0) begin
                    check("deliver_unexpected", fs_to_ds_bus, 65'd0);
                    if (fs_to_ds_bus == 65'd0) begin
                        n_bad++;
                        $display("FAIL deliver_unexpected: got an entry with nothing expected");
                    end
                end else begin
                    e = exp_q.pop_front();
                    check("deliver", fs_to_ds_bus, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        reset = 1'b1; flush = 1'b0; new_pc = '0; br_bus = '0;
        inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0; ds_allow_in = 1'b0;
        nx_reset = 1'b1; nx_flush = 1'b0; nx_br = 1'b0; nx_ok = 1'b1;
        nx_resp = 1'b1; nx_allow = 1'b1; nx_new_pc = '0; nx_target = '0;

        // Reset state
        step();
        step();
        check("rst_req", 65'(inst_req), 65'd0);
        check("rst_valid", 65'(fs_to_ds_valid), 65'd0);
        check("rst_bus", fs_to_ds_bus, 65'd0);

        // Streaming fetch with one-cycle responses
        nx_reset = 1'b0;
        step();
        check("first_req", 65'(inst_req), 65'd1);
        check("first_addr", 65'(inst_addr), 65'(RESET_PC));
        step();
        check("lat_not_yet", 65'(fs_to_ds_valid), 65'd0);
        check("second_addr", 65'(last_acc), 65'(32'h1c00_0004));
        step();
        check("lat_valid", 65'(fs_to_ds_valid), 65'd1);
        check("lat_head", fs_to_ds_bus, {mem(RESET_PC), 1'b0, RESET_PC});
        repeat (8) step();
        check("stream_count", 65'(n_acc), 65'd11);
        drain();

        // Back-pressure: exactly DEPTH accepts, then drain in order
        nx_allow = 1'b0;
        nx_ok    = 1'b1;
        a0 = n_acc;
        repeat (10) step();
        check("bp_accepts", 65'(n_acc - a0), 65'(DEPTH));
        check("bp_req_low", 65'(inst_req), 65'd0);
        check("bp_head_valid", 65'(fs_to_ds_valid), 65'd1);
        nx_allow = 1'b1;
        nx_ok    = 1'b0;
        repeat (6) step();
        check("bp_drained", 65'(exp_q.size()), 65'd0);
        nx_ok = 1'b1;
        step();
        check("bp_resume_req", 65'(inst_req), 65'd1);
        check("bp_resume_addr", 65'(inst_addr), 65'(last_acc));
        drain();

        // Branch with three requests in flight
        nx_ok   = 1'b1;
        nx_resp = 1'b0;
        a0 = n_acc;
        repeat (3) step();
        check("br_inflight", 65'(n_acc - a0), 65'd3);
        nx_ok = 1'b0;
        nx_br = 1'b1;
        nx_target = 32'h1c00_0100;
        step();
        nx_ok = 1'b1;
        a0 = n_acc;
        step();
        check("br_req", 65'(inst_req), 65'd1);
        check("br_addr", 65'(inst_addr), 65'(32'h1c00_0100));
        step();
        check("br_blocked", 65'(inst_req), 65'd0);
        check("br_one_acc", 65'(n_acc - a0), 65'd1);
        nx_resp = 1'b1;
        step();
        check("br_still_blocked", 65'(inst_req), 65'd0);
        check("br_no_stale", 65'(fs_to_ds_valid), 65'd0);
        repeat (6) step();
        drain();

        // Flush and branch together, with a response in the same cycle
        nx_ok   = 1'b1;
        nx_resp = 1'b0;
        repeat (3) step();
        nx_ok     = 1'b0;
        nx_resp   = 1'b1;
        nx_flush  = 1'b1;
        nx_new_pc = 32'h1c00_8000;
        nx_br     = 1'b1;
        nx_target = 32'h1c00_0200;
        step();
        nx_resp = 1'b0;
        nx_ok   = 1'b1;
        a0 = n_acc;
        step();
        check("fl_addr", 65'(inst_addr), 65'(32'h1c00_8000));
        check("fl_req", 65'(inst_req), 65'd1);
        step();
        step();
        check("fl_discard_two", 65'(n_acc - a0), 65'd2);
        check("fl_blocked", 65'(inst_req), 65'd0);
        nx_resp = 1'b1;
        repeat (6) step();
        drain();

        // Misaligned branch target raises ADEF and halts until flush
        nx_ok = 1'b1;
        nx_br = 1'b1;
        nx_target = 32'h1c00_0102;
        step();
        exp_q.push_back({32'h0, 1'b1, 32'h1c00_0102});
        a0 = n_acc;
        step();
        check("adef_no_req", 65'(inst_req), 65'd0);
        repeat (5) step();
        check("adef_halt_req", 65'(inst_req), 65'd0);
        check("adef_halt_acc", 65'(n_acc - a0), 65'd0);
        check("adef_delivered", 65'(exp_q.size()), 65'd0);
        nx_flush  = 1'b1;
        nx_new_pc = 32'h1c00_8000;
        step();
        step();
        check("adef_resume_req", 65'(inst_req), 65'd1);
        check("adef_resume_addr", 65'(inst_addr), 65'(32'h1c00_8000));
        repeat (4) step();
        drain();

        // Redirect while addr_ok is held low
        a0 = n_acc;
        step();
        check("hold_req", 65'(inst_req), 65'd1);
        check("hold_addr", 65'(inst_addr), 65'(last_acc + 32'd4));
        nx_br = 1'b1;
        nx_target = 32'h1c00_0300;
        step();
        step();
        check("hold_new_addr", 65'(inst_addr), 65'(32'h1c00_0300));
        step();
        step();
        check("hold_no_acc", 65'(n_acc - a0), 65'd0);
        nx_ok = 1'b1;
        step();
        check("hold_acc_pc", 65'(last_acc), 65'(32'h1c00_0300));
        repeat (4) step();
        drain();

        // Reset in the middle of traffic
        nx_ok = 1'b1;
        repeat (3) step();
        nx_reset = 1'b1;
        step();
        step();
        check("mid_rst_req", 65'(inst_req), 65'd0);
        check("mid_rst_valid", 65'(fs_to_ds_valid), 65'd0);
        check("mid_rst_bus", fs_to_ds_bus, 65'd0);
        nx_reset = 1'b0;
        step();
        check("mid_rst_addr", 65'(inst_addr), 65'(RESET_PC));
        repeat (4) step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
